s4ga_cfg_sequencer: RTL and testbench

//  Sequences the s4ga LUT fabric: timed fabric reset, then streams LUT config segments (SI_W bits/clk) from a shared config RAM onto si.

---
 rtl/s4ga_pkg.sv | 27 ++
 rtl/s4ga_seg_addr_gen.sv | 27 ++
 rtl/s4ga_cfg_sequencer.sv | 123 ++++++++++++
 tb/tb_s4ga_cfg_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/s4ga_pkg.sv
// Frame geometry shared by the s4ga fabric and its config sequencer, plus sequencer state encoding.
// Keeping both in one place stops the LUT segment layout from drifting between the two sides.
package s4ga_pkg;

  typedef enum logic [1:0] {IDLE, RESET, RUN} seq_state_t;

  function automatic int idx_w(input int n, input int i);
    return $clog2(3 + i + n);
  endfunction

  function automatic int idx_segs(input int n, input int i, input int si_w);
    return (idx_w(n, i) + si_w - 1) / si_w;
  endfunction

  function automatic int mask_segs(input int k, input int si_w);
    return ((1 << k) + si_w - 1) / si_w;
  endfunction

  function automatic int lut_segs(input int n, input int k, input int i, input int si_w);
    return k * idx_segs(n, i, si_w) + mask_segs(k, si_w);
  endfunction

  function automatic int frame_segs(input int n, input int k, input int i, input int si_w);
    return n * lut_segs(n, k, i, si_w);
  endfunction

endpackage

// File: rtl/s4ga_seg_addr_gen.sv
// Segment address counter that wraps at LAST with no idle cycle; clr wins over en.
// Also serves as the fabric-reset hold timer, which is why clr is exposed separately.
module s4ga_seg_addr_gen #(
  parameter int ADDR_W = 6,
  parameter int LAST   = 55
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] cnt,
  output logic              last
);

  assign last = (cnt == ADDR_W'(LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/s4ga_cfg_sequencer.sv
// Holds the s4ga fabric in reset for a timed interval, then streams config segments from the
// shared RAM onto si; the single RAM port belongs to the host in IDLE and to the streamer otherwise.
module s4ga_cfg_sequencer
  import s4ga_pkg::*;
#(
  parameter int N          = 241,
  parameter int K          = 5,
  parameter int I          = 2,
  parameter int SI_W       = 4,
  parameter int RST_CYCLES = N + 2,
  parameter int FCNT_W     = 16,
  localparam int FRAME_SEGS = frame_segs(N, K, I, SI_W),
  localparam int ADDR_W     = $clog2(FRAME_SEGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  input  logic              stop_req,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [SI_W-1:0]   wr_data,
  output logic              wr_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [SI_W-1:0]   mem_wdata,
  input  logic [SI_W-1:0]   mem_rdata,
  output logic              fab_rst,
  output logic [SI_W-1:0]   si,
  output logic              busy,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt
);

  seq_state_t        state;
  logic              cont_q, stop_pend;
  logic [ADDR_W-1:0] seg_addr;
  logic              seg_last, hold_done, frame_end;
  logic              vld_p0, vld_p1, vld_p2, last_p1;

  assign hold_done = (state == RESET) && (seg_addr == ADDR_W'(RST_CYCLES - 1));
  assign frame_end = (state == RUN) && seg_last && (!cont_q || stop_pend || stop_req);
  assign vld_p0    = (state == RUN);

  s4ga_seg_addr_gen #(
    .ADDR_W (ADDR_W),
    .LAST   (FRAME_SEGS - 1)
  ) u_addr_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((state == IDLE) || hold_done),
    .en    (state != IDLE),
    .cnt   (seg_addr),
    .last  (seg_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cont_q    <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      if (stop_req) stop_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (start && !stop_req) begin
            cont_q <= continuous;
            state  <= RESET;
          end
        end
        RESET: if (hold_done) state <= RUN;
        RUN: begin
          if (frame_end) begin
            state     <= IDLE;
            stop_pend <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Host writes pass straight through in IDLE; reset forces the port quiet.
  always_comb begin
    wr_ready = (state == IDLE);
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = wr_addr;
    if (state == RUN) begin
      mem_en   = 1'b1;
      mem_addr = seg_addr;
    end else if ((state == IDLE) && wr_valid && rst_n) begin
      mem_en = 1'b1;
      mem_we = 1'b1;
    end
  end

  assign mem_wdata = wr_data;
  assign busy      = (state != IDLE) || vld_p1 || vld_p2;

  // p0: address issued -> p1: RAM data valid -> p2: segment on si, fabric out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      last_p1    <= 1'b0;
      si         <= '0;
      fab_rst    <= 1'b1;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      vld_p1     <= vld_p0;
      last_p1    <= vld_p0 && seg_last;
      vld_p2     <= vld_p1;
      fab_rst    <= !vld_p1;
      si         <= vld_p1 ? mem_rdata : '0;
      frame_done <= vld_p1 && last_p1;
      if (vld_p1 && last_p1) frame_cnt <= frame_cnt + FCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_s4ga_cfg_sequencer.sv
// Bench for s4ga_cfg_sequencer at N=7,K=4,I=2,SI_W=4 (56-segment frame, 9-cycle reset hold).
// A RAM model answers the DUT; expected streams come from a shadow copy of the host writes.
module tb_s4ga_cfg_sequencer;

  localparam int N      = 7;
  localparam int K      = 4;
  localparam int I      = 2;
  localparam int SI_W   = 4;
  localparam int R      = 9;
  localparam int FCNT_W = 2;
  localparam int FS     = 56;
  localparam int AW     = 6;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0, continuous = 1'b0, stop_req = 1'b0;
  logic            wr_valid = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [SI_W-1:0] wr_data = '0;
  logic            wr_ready, mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [SI_W-1:0] mem_wdata;
  logic [SI_W-1:0] mem_rdata = '0;
  logic            fab_rst, busy, frame_done;
  logic [SI_W-1:0] si;
  logic [FCNT_W-1:0] frame_cnt;

  logic [SI_W-1:0] ram [FS];
  logic [SI_W-1:0] exp_ram [FS];
  int n_cmp = 0;
  int n_bad = 0;
  int model_cnt = 0;

  s4ga_cfg_sequencer #(
    .N(N), .K(K), .I(I), .SI_W(SI_W), .RST_CYCLES(R), .FCNT_W(FCNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .stop_req(stop_req),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .fab_rst(fab_rst), .si(si), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (mem_en && mem_we && int'(mem_addr) < FS) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we && int'(mem_addr) < FS) mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic          wv;
    logic [AW-1:0] wa;
    logic [3:0]    wd;
    logic          e_en;
    logic          e_we;
    logic          e_rdy;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic clear_inputs();
    start = 1'b0; stop_req = 1'b0; wr_valid = 1'b0; continuous = 1'b0;
  endtask

  task automatic host_write(input int a, input logic [3:0] d);
    wr_valid = 1'b1; wr_addr = AW'(a); wr_data = d;
    #1;
    check("idle_write_we", mem_we, 1);
    step();
    wr_valid = 1'b0;
    exp_ram[a] = d;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    model_cnt = 0;
    step();
  endtask

  // Start one sequencing run and check every cycle until the fabric is back in reset.
  // Frame f is the last one when, at the cycle its final address issues, the run is
  // single-frame or a stop has been requested.
  task automatic run(input bit cont, input int stop_c, input bit inject, input int abort_c);
    int nfr, s, f, j, fidx;
    bit stop_seen, active, issuing;
    nfr = -1;
    stop_seen = 1'b0;
    start = 1'b1; continuous = cont; stop_req = 1'b0;
    step();
    clear_inputs();
    for (int c = 1; c < 2000; c++) begin
      if (c <= R + 2) begin
        check("hold_fab_rst", fab_rst, 1);
        check("hold_si", si, 0);
        check("hold_done", frame_done, 0);
        check("hold_busy", busy, 1);
        check("hold_cnt", frame_cnt, model_cnt % 4);
      end else begin
        s = c - R - 3; f = s / FS; j = s % FS;
        if (nfr >= 0 && f >= nfr) begin
          check("end_fab_rst", fab_rst, 1);
          check("end_si", si, 0);
          check("end_done", frame_done, 0);
          check("end_busy", busy, 0);
          model_cnt = (model_cnt + nfr) % 4;
          check("end_cnt", frame_cnt, model_cnt);
          return;
        end
        check("run_fab_rst", fab_rst, 0);
        check("run_si", si, exp_ram[j]);
        check("run_done", frame_done, (j == FS - 1) ? 1 : 0);
        check("run_busy", busy, 1);
        check("run_cnt", frame_cnt, (model_cnt + f + ((j == FS - 1) ? 1 : 0)) % 4);
      end
      if (c == abort_c) return;
      stop_req = (c == stop_c);
      if (stop_req) stop_seen = 1'b1;
      active = (nfr < 0) || (c <= R + nfr * FS);
      issuing = active && (c >= R + 1);
      if (inject && active) begin
        wr_valid = 1'($urandom_range(0, 1));
        wr_addr = AW'($urandom_range(0, FS - 1));
        wr_data = 4'($urandom);
        start = 1'($urandom_range(0, 1));
        continuous = 1'($urandom_range(0, 1));
      end else begin
        wr_valid = 1'b0; start = 1'b0;
      end
      #1;
      check("wr_ready", wr_ready, active ? 0 : 1);
      check("mem_we", mem_we, 0);
      check("mem_en", mem_en, issuing ? 1 : 0);
      if (issuing) check("mem_addr", mem_addr, (c - R - 1) % FS);
      if (issuing && nfr < 0 && (c - R - 1) % FS == FS - 1) begin
        fidx = (c - R - 1) / FS;
        if (!cont || stop_seen) nfr = fidx + 1;
      end
      step();
      clear_inputs();
    end
    check("run_timeout", 0, 1);
  endtask

  initial begin
    vec_t tbl [4];
    tbl[0] = '{wv: 1'b0, wa: 6'd3,  wd: 4'h9, e_en: 1'b0, e_we: 1'b0, e_rdy: 1'b1};
    tbl[1] = '{wv: 1'b1, wa: 6'd5,  wd: 4'hA, e_en: 1'b1, e_we: 1'b1, e_rdy: 1'b1};
    tbl[2] = '{wv: 1'b1, wa: 6'd55, wd: 4'h3, e_en: 1'b1, e_we: 1'b1, e_rdy: 1'b1};
    tbl[3] = '{wv: 1'b0, wa: 6'd0,  wd: 4'h0, e_en: 1'b0, e_we: 1'b0, e_rdy: 1'b1};

    // reset state, sampled while rst_n is held low
    step();
    step();
    check("rst_fab_rst", fab_rst, 1);
    check("rst_si", si, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_mem_en", mem_en, 0);
    rst_n = 1'b1;
    step();

    // IDLE host-port vectors
    for (int v = 0; v < 4; v++) begin
      wr_valid = tbl[v].wv; wr_addr = tbl[v].wa; wr_data = tbl[v].wd;
      #1;
      check("tbl_mem_en", mem_en, tbl[v].e_en);
      check("tbl_mem_we", mem_we, tbl[v].e_we);
      check("tbl_wr_ready", wr_ready, tbl[v].e_rdy);
      if (tbl[v].e_en) begin
        check("tbl_mem_addr", mem_addr, tbl[v].wa);
        check("tbl_mem_wdata", mem_wdata, tbl[v].wd);
      end
      step();
      if (tbl[v].e_we) exp_ram[tbl[v].wa] = tbl[v].wd;
    end
    wr_valid = 1'b0;

    // single frame of i[3:0]
    for (int a = 0; a < FS; a++) host_write(a, 4'(a));
    run(1'b0, -1, 1'b0, -1);

    // three back-to-back frames, stop mid-frame 3, host traffic and starts ignored
    do_reset();
    for (int a = 0; a < FS; a++) host_write(a, 4'($urandom));
    run(1'b1, R + 3 + 2 * FS + 20, 1'b1, -1);
    check("three_frames_cnt", frame_cnt, 3);

    // counter wraps 3 -> 0 across two back-to-back frames
    run(1'b1, R + 3 + FS + 5, 1'b0, -1);
    check("wrap_cnt", frame_cnt, 1);

    // start and stop together in IDLE: nothing happens
    start = 1'b1; stop_req = 1'b1; continuous = 1'b1;
    step();
    clear_inputs();
    for (int c = 0; c < 4; c++) begin
      check("startstop_busy", busy, 0);
      check("startstop_fab_rst", fab_rst, 1);
      check("startstop_mem_en", mem_en, 0);
      step();
    end

    // reset while segment 20 is on si
    run(1'b0, -1, 1'b0, R + 3 + 20);
    check("pre_abort_si", si, exp_ram[20]);
    rst_n = 1'b0;
    #1;
    check("abort_fab_rst", fab_rst, 1);
    check("abort_si", si, 0);
    check("abort_busy", busy, 0);
    check("abort_cnt", frame_cnt, 0);
    step();
    rst_n = 1'b1;
    model_cnt = 0;
    step();
    run(1'b0, -1, 1'b0, -1);

    // stop requested during the reset hold: exactly one frame
    run(1'b1, 3, 1'b0, -1);
    check("stop_in_reset_cnt", frame_cnt, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
